// File: rtl/machine_pkg.sv
// Shared definitions for the tiny accumulator-less register machine:
// opcode values, FSM states and instruction field offsets.
package machine_pkg;

    localparam int OPC_W  = 5;
    localparam int RSEL_W = 2;

    // Field LSB positions measured from the top of the imm field (imm occupies [DW-1:0]).
    localparam int RS_OFS  = 0;
    localparam int RD_OFS  = 2;
    localparam int OPC_OFS = 4;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_NOT = 5'd6;
    localparam logic [4:0] OP_LDI = 5'd7;
    localparam logic [4:0] OP_MOV = 5'd8;
    localparam logic [4:0] OP_JMP = 5'd9;
    localparam logic [4:0] OP_JZ  = 5'd10;
    localparam logic [4:0] OP_JC  = 5'd11;
    localparam logic [4:0] OP_OUT = 5'd12;
    localparam logic [4:0] OP_HLT = 5'd31;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    function automatic logic writes_reg(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    function automatic logic writes_flags(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/machine_alu.sv
// Combinational ALU: result/carry/zero for the data opcodes; other opcodes yield 0.
module machine_alu
    import machine_pkg::*;
#(
    parameter int DW = 2
) (
    input  logic [4:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_result,
    output logic          o_carry,
    output logic          o_zero
);

    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The extra MSB of the difference is the unsigned borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin o_result = w_sum[DW-1:0];  o_carry = w_sum[DW];  end
            OP_SUB: begin o_result = w_diff[DW-1:0]; o_carry = w_diff[DW]; end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_NOT: o_result = ~i_b;
            OP_LDI: o_result = i_b;
            OP_MOV: o_result = i_b;
            default: begin o_result = '0; o_carry = 1'b0; end
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/machine_core.sv
// Two-phase (fetch/exec) register machine stepped by a divided tick from fast_clk.
// All architectural state and outputs are registered; run_en low freezes everything.
module machine_core
    import machine_pkg::*;
#(
    parameter  int DW  = 2,
    parameter  int PW  = 3,
    parameter  int DIV = 4,
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          fast_clk,
    input  logic          rst,
    input  logic          run_en,
    input  logic [8+DW:0] instr_data,
    output logic [PW-1:0] instr_addr,
    output logic [CW-1:0] ubCounter,
    output logic [4:0]    opcd,
    output logic [DW-1:0] in1,
    output logic [DW-1:0] in2,
    output logic [DW-1:0] resul,
    output logic          flag,
    output logic          carry,
    output logic          led,
    output logic          halted
);

    state_e        r_state;
    logic [CW-1:0] r_div;
    logic [PW-1:0] r_pc;
    logic [8+DW:0] r_ir;
    logic [DW-1:0] r_regs [4];
    logic [4:0]    r_opcd;
    logic [DW-1:0] r_in1, r_in2, r_res;
    logic          r_flag, r_carry, r_led, r_halted;

    logic                w_tick;
    logic [4:0]          w_op;
    logic [RSEL_W-1:0]   w_rd, w_rs;
    logic [DW-1:0]       w_imm, w_a, w_b, w_res;
    logic                w_carry, w_zero, w_jump;
    logic [PW-1:0]       w_pc_next;

    assign w_tick = run_en && (r_div == CW'(DIV - 1));

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (run_en) begin
            r_div <= (r_div == CW'(DIV - 1)) ? '0 : r_div + CW'(1);
        end
    end

    assign w_op  = r_ir[DW+OPC_OFS +: OPC_W];
    assign w_rd  = r_ir[DW+RD_OFS  +: RSEL_W];
    assign w_rs  = r_ir[DW+RS_OFS  +: RSEL_W];
    assign w_imm = r_ir[DW-1:0];
    assign w_a   = r_regs[w_rd];
    assign w_b   = (w_op == OP_LDI) ? w_imm : r_regs[w_rs];

    machine_alu #(.DW(DW)) u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_res),
        .o_carry  (w_carry),
        .o_zero   (w_zero)
    );

    assign w_jump    = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_flag) || ((w_op == OP_JC) && r_carry);
    assign w_pc_next = w_jump ? PW'(w_imm) : r_pc + PW'(1);

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_opcd   <= '0;
            r_in1    <= '0;
            r_in2    <= '0;
            r_res    <= '0;
            r_flag   <= 1'b0;
            r_carry  <= 1'b0;
            r_led    <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= instr_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_opcd <= w_op;
                    r_in1  <= w_a;
                    r_in2  <= w_b;
                    if (writes_reg(w_op)) begin
                        r_regs[w_rd] <= w_res;
                        r_res        <= w_res;
                    end
                    if (writes_flags(w_op)) begin
                        r_flag  <= w_zero;
                        r_carry <= w_carry;
                    end
                    if (w_op == OP_OUT) r_led <= w_b[0];
                    // HLT leaves the PC pointing at itself.
                    if (w_op == OP_HLT) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_pc    <= w_pc_next;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign instr_addr = r_pc;
    assign ubCounter  = r_div;
    assign opcd       = r_opcd;
    assign in1        = r_in1;
    assign in2        = r_in2;
    assign resul      = r_res;
    assign flag       = r_flag;
    assign carry      = r_carry;
    assign led        = r_led;
    assign halted     = r_halted;

endmodule

// File: tb/tb_machine_core.sv
// Bench for machine_core: directed program scenarios on a DW=2 instance and
// jump/random programs on a DW=3 instance, checked against an instruction-level model.
module tb_machine_core;

    localparam int DIV = 4;
    localparam int PW  = 3;

    logic fast_clk = 1'b0;
    logic rst      = 1'b1;
    logic run_en   = 1'b1;

    logic [10:0] a_instr;
    logic [2:0]  a_addr;
    logic [1:0]  a_ub;
    logic [4:0]  a_opcd;
    logic [1:0]  a_in1, a_in2, a_res;
    logic        a_flag, a_carry, a_led, a_halted;

    logic [11:0] b_instr;
    logic [2:0]  b_addr;
    logic [1:0]  b_ub;
    logic [4:0]  b_opcd;
    logic [2:0]  b_in1, b_in2, b_res;
    logic        b_flag, b_carry, b_led, b_halted;

    logic [10:0] rom_a [8];
    logic [11:0] rom_b [8];

    assign a_instr = rom_a[a_addr];
    assign b_instr = rom_b[b_addr];

    always #5 fast_clk = ~fast_clk;

    machine_core #(.DW(2), .PW(PW), .DIV(DIV)) u_dut_a (
        .fast_clk(fast_clk), .rst(rst), .run_en(run_en), .instr_data(a_instr),
        .instr_addr(a_addr), .ubCounter(a_ub), .opcd(a_opcd), .in1(a_in1), .in2(a_in2),
        .resul(a_res), .flag(a_flag), .carry(a_carry), .led(a_led), .halted(a_halted)
    );

    machine_core #(.DW(3), .PW(PW), .DIV(DIV)) u_dut_b (
        .fast_clk(fast_clk), .rst(rst), .run_en(run_en), .instr_data(b_instr),
        .instr_addr(b_addr), .ubCounter(b_ub), .opcd(b_opcd), .in1(b_in1), .in2(b_in2),
        .resul(b_res), .flag(b_flag), .carry(b_carry), .led(b_led), .halted(b_halted)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction-level reference state.
    int m_regs [4];
    int m_pc, m_flag, m_carry, m_led, m_halt, m_opcd, m_in1, m_in2, m_res;

    function automatic int enc(input int dw, input int op, input int rd, input int rs, input int imm);
        return (op << (dw + 4)) | (rd << (dw + 2)) | (rs << dw) | imm;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_pc = 0; m_flag = 0; m_carry = 0; m_led = 0; m_halt = 0;
        m_opcd = 0; m_in1 = 0; m_in2 = 0; m_res = 0;
    endtask

    task automatic model_exec(input int dw, input int word);
        int md, op, rd, rs, imm, a, b, r, npc;
        if (m_halt != 0) return;
        md  = 1 << dw;
        op  = (word >> (dw + 4)) & 31;
        rd  = (word >> (dw + 2)) & 3;
        rs  = (word >> dw) & 3;
        imm = word % md;
        a   = m_regs[rd];
        b   = m_regs[rs];
        r   = 0;
        npc = (m_pc + 1) % (1 << PW);
        m_opcd = op;
        m_in1  = a;
        m_in2  = (op == 7) ? imm : b;
        case (op)
            1:  begin r = (a + b) % md;      m_carry = (a + b >= md) ? 1 : 0; end
            2:  begin r = (a - b + md) % md; m_carry = (a < b) ? 1 : 0; end
            3:  begin r = a & b;             m_carry = 0; end
            4:  begin r = a | b;             m_carry = 0; end
            5:  begin r = a ^ b;             m_carry = 0; end
            6:  begin r = md - 1 - b;        m_carry = 0; end
            7:  r = imm;
            8:  r = b;
            9:  npc = imm % (1 << PW);
            10: if (m_flag != 0) npc = imm % (1 << PW);
            11: if (m_carry != 0) npc = imm % (1 << PW);
            12: m_led = b % 2;
            31: begin m_halt = 1; npc = m_pc; end
            default: ;
        endcase
        if (op >= 1 && op <= 8) begin m_regs[rd] = r; m_res = r; end
        if (op >= 1 && op <= 6) m_flag = (r == 0) ? 1 : 0;
        m_pc = npc;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        run_en = 1'b1;
        repeat (2) @(posedge fast_clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic run_instr();
        repeat (2 * DIV) @(posedge fast_clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 8; i++) begin rom_a[i] = '0; rom_b[i] = '0; end
    endtask

    task automatic test_reset();
        fill_nop();
        rst = 1'b1;
        repeat (2) @(posedge fast_clk);
        #1;
        checks++;
        if ({a_addr, a_ub, a_opcd, a_in1, a_in2, a_res, a_flag, a_carry, a_led, a_halted} !== 18'd0) begin
            failures++;
            $display("FAIL reset_a outputs=%h required=0", {a_addr, a_ub, a_opcd, a_in1, a_in2, a_res, a_flag, a_carry, a_led, a_halted});
        end
        checks++;
        if ({b_addr, b_ub, b_opcd, b_in1, b_in2, b_res, b_flag, b_carry, b_led, b_halted} !== 21'd0) begin
            failures++;
            $display("FAIL reset_b outputs=%h required=0", {b_addr, b_ub, b_opcd, b_in1, b_in2, b_res, b_flag, b_carry, b_led, b_halted});
        end
    endtask

    task automatic test_add_carry();
        fill_nop();
        rom_a[0] = 11'(enc(2, 7, 0, 0, 2));
        rom_a[1] = 11'(enc(2, 7, 1, 0, 3));
        rom_a[2] = 11'(enc(2, 1, 0, 1, 0));
        apply_reset();
        run_instr();
        checks++;
        if (a_res !== 2'd2 || a_addr !== 3'd1) begin
            failures++;
            $display("FAIL ldi_r0 resul=%0d addr=%0d required resul=2 addr=1", a_res, a_addr);
        end
        run_instr();
        repeat (2 * DIV - 1) @(posedge fast_clk);
        #1;
        checks++;
        if (a_opcd !== 5'd7) begin
            failures++;
            $display("FAIL add_span opcd=%0d required=7 one cycle before exec", a_opcd);
        end
        @(posedge fast_clk);
        #1;
        checks++;
        if (a_res !== 2'd1 || a_carry !== 1'b1 || a_flag !== 1'b0 || a_opcd !== 5'd1) begin
            failures++;
            $display("FAIL add_carry resul=%0d carry=%0d flag=%0d opcd=%0d required 1/1/0/1", a_res, a_carry, a_flag, a_opcd);
        end
        checks++;
        if (a_in1 !== 2'd2 || a_in2 !== 2'd3 || a_addr !== 3'd3) begin
            failures++;
            $display("FAIL add_operands in1=%0d in2=%0d addr=%0d required 2/3/3", a_in1, a_in2, a_addr);
        end
    endtask

    task automatic test_sub_jz();
        fill_nop();
        rom_b[0] = 12'(enc(3, 7, 0, 0, 1));
        rom_b[1] = 12'(enc(3, 2, 0, 0, 0));
        rom_b[2] = 12'(enc(3, 10, 0, 0, 5));
        apply_reset();
        run_instr();
        run_instr();
        checks++;
        if (b_res !== 3'd0 || b_flag !== 1'b1 || b_carry !== 1'b0) begin
            failures++;
            $display("FAIL sub_zero resul=%0d flag=%0d carry=%0d required 0/1/0", b_res, b_flag, b_carry);
        end
        run_instr();
        checks++;
        if (b_addr !== 3'd5) begin
            failures++;
            $display("FAIL jz_taken addr=%0d required=5", b_addr);
        end
    endtask

    task automatic test_pc_wrap();
        fill_nop();
        apply_reset();
        checks++;
        if (a_addr !== 3'd0) begin
            failures++;
            $display("FAIL wrap_start addr=%0d required=0", a_addr);
        end
        for (int i = 1; i <= 8; i++) begin
            run_instr();
            checks++;
            if (a_addr !== 3'(i % 8)) begin
                failures++;
                $display("FAIL wrap_step%0d addr=%0d required=%0d", i, a_addr, i % 8);
            end
        end
    endtask

    task automatic test_out_hlt();
        fill_nop();
        rom_a[0] = 11'(enc(2, 7, 2, 0, 1));
        rom_a[1] = 11'(enc(2, 12, 0, 2, 0));
        rom_a[2] = 11'(enc(2, 31, 0, 0, 0));
        apply_reset();
        run_instr();
        run_instr();
        checks++;
        if (a_led !== 1'b1 || a_halted !== 1'b0) begin
            failures++;
            $display("FAIL out_led led=%0d halted=%0d required 1/0", a_led, a_halted);
        end
        run_instr();
        checks++;
        if (a_halted !== 1'b1 || a_addr !== 3'd2 || a_opcd !== 5'd31) begin
            failures++;
            $display("FAIL hlt halted=%0d addr=%0d opcd=%0d required 1/2/31", a_halted, a_addr, a_opcd);
        end
        for (int t = 0; t < 20; t++) begin
            repeat (DIV) @(posedge fast_clk);
            #1;
            checks++;
            if (a_addr !== 3'd2 || a_halted !== 1'b1 || a_led !== 1'b1) begin
                failures++;
                $display("FAIL hlt_hold tick%0d addr=%0d halted=%0d led=%0d required 2/1/1", t, a_addr, a_halted, a_led);
            end
        end
    endtask

    task automatic test_freeze();
        fill_nop();
        rom_a[0] = 11'(enc(2, 7, 0, 0, 2));
        rom_a[1] = 11'(enc(2, 7, 1, 0, 3));
        rom_a[2] = 11'(enc(2, 1, 0, 1, 0));
        apply_reset();
        run_instr();
        repeat (DIV + 2) @(posedge fast_clk);
        #1 run_en = 1'b0;
        repeat (50) @(posedge fast_clk);
        #1;
        checks++;
        if (a_ub !== 2'd2 || a_addr !== 3'd1 || a_res !== 2'd2 || a_opcd !== 5'd7 || a_in2 !== 2'd2) begin
            failures++;
            $display("FAIL freeze ub=%0d addr=%0d resul=%0d opcd=%0d in2=%0d required 2/1/2/7/2", a_ub, a_addr, a_res, a_opcd, a_in2);
        end
        run_en = 1'b1;
        repeat (DIV - 2) @(posedge fast_clk);
        #1;
        checks++;
        if (a_res !== 2'd3 || a_addr !== 3'd2 || a_in1 !== 2'd0 || a_in2 !== 2'd3) begin
            failures++;
            $display("FAIL resume resul=%0d addr=%0d in1=%0d in2=%0d required 3/2/0/3", a_res, a_addr, a_in1, a_in2);
        end
        run_instr();
        checks++;
        if (a_res !== 2'd1 || a_carry !== 1'b1 || a_flag !== 1'b0) begin
            failures++;
            $display("FAIL resume_add resul=%0d carry=%0d flag=%0d required 1/1/0", a_res, a_carry, a_flag);
        end
    endtask

    task automatic test_rst_mid_exec();
        fill_nop();
        rom_a[0] = 11'(enc(2, 7, 0, 0, 3));
        rom_a[1] = 11'(enc(2, 7, 1, 0, 1));
        rom_a[2] = 11'(enc(2, 1, 0, 1, 0));
        apply_reset();
        run_instr();
        run_instr();
        repeat (DIV + 1) @(posedge fast_clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_addr, a_ub, a_opcd, a_in1, a_in2, a_res, a_flag, a_carry, a_led, a_halted} !== 18'd0) begin
            failures++;
            $display("FAIL rst_async outputs=%h required=0", {a_addr, a_ub, a_opcd, a_in1, a_in2, a_res, a_flag, a_carry, a_led, a_halted});
        end
        rom_a[0] = 11'(enc(2, 1, 0, 1, 0));
        rom_a[1] = 11'(enc(2, 1, 2, 3, 0));
        @(posedge fast_clk);
        #1 rst = 1'b0;
        checks++;
        if (a_addr !== 3'd0) begin
            failures++;
            $display("FAIL rst_fetch_addr addr=%0d required=0", a_addr);
        end
        run_instr();
        checks++;
        if (a_res !== 2'd0 || a_flag !== 1'b1 || a_carry !== 1'b0 || a_in1 !== 2'd0 || a_in2 !== 2'd0 || a_addr !== 3'd1) begin
            failures++;
            $display("FAIL rst_regs_clear resul=%0d flag=%0d carry=%0d in1=%0d in2=%0d addr=%0d required 0/1/0/0/0/1",
                     a_res, a_flag, a_carry, a_in1, a_in2, a_addr);
        end
    endtask

    task automatic test_random_programs();
        int op;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 15)      op = 31;
                else if (op >= 13) op = int'($urandom_range(13, 30));
                rom_b[i] = 12'(enc(3, op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7))));
            end
            apply_reset();
            for (int k = 0; k < 40; k++) begin
                model_exec(3, int'(rom_b[m_pc]));
                run_instr();
                checks++;
                if (b_addr !== 3'(m_pc) || b_halted !== 1'(m_halt)) begin
                    failures++;
                    $display("FAIL rnd_pc p%0d k%0d addr=%0d halted=%0d required %0d/%0d", p, k, b_addr, b_halted, m_pc, m_halt);
                end
                checks++;
                if (b_opcd !== 5'(m_opcd) || b_in1 !== 3'(m_in1) || b_in2 !== 3'(m_in2)) begin
                    failures++;
                    $display("FAIL rnd_ops p%0d k%0d opcd=%0d in1=%0d in2=%0d required %0d/%0d/%0d",
                             p, k, b_opcd, b_in1, b_in2, m_opcd, m_in1, m_in2);
                end
                checks++;
                if (b_res !== 3'(m_res) || b_flag !== 1'(m_flag) || b_carry !== 1'(m_carry) || b_led !== 1'(m_led)) begin
                    failures++;
                    $display("FAIL rnd_res p%0d k%0d resul=%0d flag=%0d carry=%0d led=%0d required %0d/%0d/%0d/%0d",
                             p, k, b_res, b_flag, b_carry, b_led, m_res, m_flag, m_carry, m_led);
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_carry();
        test_sub_jz();
        test_pc_wrap();
        test_out_hlt();
        test_freeze();
        test_rst_mid_exec();
        test_random_programs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
